// File: rtl/udma_i2c_pkg.sv
// -----------------------------------------------------------------------------
// udma_i2c_pkg
// Shared definitions for the I2C uDMA datapath: uDMA datasize codes and the
// RX packer state encoding.
// -----------------------------------------------------------------------------
package udma_i2c_pkg;

  // uDMA datasize codes carried alongside each RX word
  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  // RX packer FSM encoding
  typedef logic [0:0] rx_state_t;
  localparam rx_state_t ST_FILL  = 1'b0;
  localparam rx_state_t ST_FLUSH = 1'b1;

endpackage

// File: rtl/udma_i2c_rx_packer.sv
// -----------------------------------------------------------------------------
// udma_i2c_rx_packer
// Packs the I2C controller RX byte stream little-endian into 32-bit uDMA words
// (or passes bytes through one per word in bypass mode). On eot the partial
// word is flushed using legal uDMA sizes only (word, half, byte).
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   sw_rst_i            soft reset, synchronous clear (bytes drained meanwhile)
//   pack_en_i           1 = pack 4 bytes/word, 0 = one byte per word
//   byte_i/_valid_i/_ready_o   RX byte stream from the controller
//   eot_i               single-cycle flush request
//   word_o/word_size_o/word_valid_o/word_ready_i  output to the uDMA RX channel
//   flush_done_o        one-cycle pulse when a flush has completed
// -----------------------------------------------------------------------------
module udma_i2c_rx_packer
  import udma_i2c_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_rst_i,
  input  logic             pack_en_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  input  logic             eot_i,
  output logic [OUT_W-1:0] word_o,
  output logic [1:0]       word_size_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             flush_done_o
);

  rx_state_t   r_state, w_state_n;
  logic [2:0]  r_cnt, w_cnt_n;
  logic [31:0] r_acc, w_acc_n;
  logic        r_pack_en;
  logic [31:0] r_word, w_word_n;
  logic [1:0]  r_size, w_size_n;
  logic        r_valid, w_valid_n;

  logic w_slot_free, w_mode, w_ready, w_accept;

  assign w_slot_free = !r_valid | word_ready_i;

  // Mode may only change on a word boundary; at that point the live input is
  // used directly so the very next byte already follows the new mode.
  assign w_mode = (r_state == ST_FILL && r_cnt == 3'd0) ? pack_en_i : r_pack_en;

  always_comb begin
    w_ready = 1'b0;
    if (rst_i)                   w_ready = 1'b0;
    else if (sw_rst_i)           w_ready = 1'b1;  // drain and discard
    else if (r_state == ST_FLUSH) w_ready = 1'b0;
    else if (w_mode)             w_ready = (r_cnt != 3'd4) | w_slot_free;
    else                         w_ready = w_slot_free;
  end

  assign w_accept = byte_valid_i & w_ready;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_acc_n   = r_acc;
    w_word_n  = r_word;
    w_size_n  = r_size;
    w_valid_n = r_valid & !word_ready_i;
    if (r_state == ST_FILL) begin
      if (!w_mode) begin
        if (w_accept) begin
          w_word_n  = {24'h0, byte_i};
          w_size_n  = DSIZE_BYTE;
          w_valid_n = 1'b1;
        end
      end else begin
        // Full accumulator moves to the slot first so a byte arriving in the
        // same cycle lands in lane 0: no bubble between words.
        if (r_cnt == 3'd4 && w_slot_free) begin
          w_word_n  = r_acc;
          w_size_n  = DSIZE_WORD;
          w_valid_n = 1'b1;
          w_cnt_n   = 3'd0;
          w_acc_n   = 32'h0;
        end
        if (w_accept) begin
          w_acc_n[{w_cnt_n[1:0], 3'b000} +: 8] = byte_i;
          w_cnt_n = w_cnt_n + 3'd1;
        end
      end
      if (eot_i) w_state_n = ST_FLUSH;
    end else begin
      if (r_cnt == 3'd0) begin
        w_state_n = ST_FILL;
      end else if (w_slot_free) begin
        w_valid_n = 1'b1;
        if (r_cnt[2]) begin
          w_word_n = r_acc;
          w_size_n = DSIZE_WORD;
          w_acc_n  = 32'h0;
          w_cnt_n  = 3'd0;
        end else if (r_cnt[1]) begin
          // 2 or 3 bytes: emit a half, any leftover byte shifts down to [7:0]
          w_word_n = {16'h0, r_acc[15:0]};
          w_size_n = DSIZE_HALF;
          w_acc_n  = {16'h0, r_acc[31:16]};
          w_cnt_n  = r_cnt - 3'd2;
        end else begin
          w_word_n = {24'h0, r_acc[7:0]};
          w_size_n = DSIZE_BYTE;
          w_acc_n  = {8'h0, r_acc[31:8]};
          w_cnt_n  = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || sw_rst_i) begin
      r_state   <= ST_FILL;
      r_cnt     <= 3'd0;
      r_acc     <= 32'h0;
      r_pack_en <= 1'b1;
      r_word    <= 32'h0;
      r_size    <= DSIZE_BYTE;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_acc     <= w_acc_n;
      r_pack_en <= w_mode;
      r_word    <= w_word_n;
      r_size    <= w_size_n;
      r_valid   <= w_valid_n;
    end
  end

  assign byte_ready_o = w_ready;
  assign word_o       = r_word;
  assign word_size_o  = r_size;
  assign word_valid_o = r_valid;
  assign flush_done_o = (r_state == ST_FLUSH) && (r_cnt == 3'd0) && !rst_i && !sw_rst_i;

endmodule
